// File: rtl/tour_length_eval.sv
// Scores a TSP tour: walks a snapshot of the path one edge per cycle, accumulating the
// closed-tour Manhattan length and checking that the path is a permutation of 0..N-1.
module tour_length_eval #(
  parameter int unsigned N       = 64,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xs [N-1:0],
  input  logic [COORD_W-1:0] ys [N-1:0],
  input  logic [IDX_W-1:0]   path [N-1:0],
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LEN_W-1:0]   length,
  output logic               perm_ok
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int unsigned   DW   = COORD_W + 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [IDX_W-1:0]   snap [N-1:0];
  logic [IDX_W-1:0]   idx;
  logic [LEN_W-1:0]   acc;
  logic [N-1:0]       seen;
  logic               dup;

  logic [IDX_W-1:0]   a;
  logic [IDX_W-1:0]   b;
  logic               last;
  logic [COORD_W:0]   dx;
  logic [COORD_W:0]   dy;
  logic [DW-1:0]      d;
  logic [LEN_W-1:0]   sum;
  logic               dup_a;

  // Current edge a->b (b wraps to the first city) and its Manhattan distance.
  always_comb begin
    a     = snap[idx];
    last  = (idx == LAST);
    b     = last ? '0 : idx + IDX_W'(1);
    b     = last ? snap[0] : snap[b];
    dx    = (xs[a] >= xs[b]) ? ({1'b0, xs[a]} - {1'b0, xs[b]})
                             : ({1'b0, xs[b]} - {1'b0, xs[a]});
    dy    = (ys[a] >= ys[b]) ? ({1'b0, ys[a]} - {1'b0, ys[b]})
                             : ({1'b0, ys[b]} - {1'b0, ys[a]});
    d     = DW'(dx) + DW'(dy);
    sum   = acc + LEN_W'(d);
    dup_a = dup | seen[a];
  end

  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (start) state_next = RUN;
    end else begin
      if (last) state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath and registered outputs; a start in IDLE snapshots the path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) snap[i] <= '0;
      idx     <= '0;
      acc     <= '0;
      seen    <= '0;
      dup     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      length  <= '0;
      perm_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          snap <= path;
          idx  <= '0;
          acc  <= '0;
          seen <= '0;
          dup  <= 1'b0;
          busy <= 1'b1;
        end
      end else begin
        acc     <= sum;
        seen[a] <= 1'b1;
        dup     <= dup_a;
        idx     <= idx + IDX_W'(1);
        // N marks made with no repeat means every index was covered.
        if (last) begin
          length  <= sum;
          perm_ok <= ~dup_a;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/tour_length_eval.md
Name: tour_length_eval

Overview:
- Downstream consumer of the tsp solver.
- Takes the city coordinate arrays (xs, ys) and the solver's tour (path) and walks the tour one edge per cycle.
- Produces the closed-tour Manhattan length and a flag saying whether path is a true permutation.
- Used to score solver output in-system and to check it in simulation without a software model.

Parameters:
- N, 64, number of cities and path entries.
- COORD_W, 8, coordinate width.
- IDX_W, 6, path index width; must be at least clog2(N).
- LEN_W, 16, accumulator and result width; must hold N*2*(2^COORD_W-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- xs  in  COORD_W x N (unpacked [N-1:0])  city x coordinates.
- ys  in  COORD_W x N (unpacked [N-1:0])  city y coordinates.
- path  in  IDX_W x N (unpacked [N-1:0])  tour order; path[k] is the k-th city visited.
- start  in  1  single-cycle request to evaluate the current path.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse when length and perm_ok are updated.
- length  out  LEN_W  sum over k of |x[a]-x[b]|+|y[a]-y[b]|, where a=path[k] and b=path[(k+1) mod N].
- perm_ok  out  1  1 when every city index 0..N-1 appears exactly once in the snapshot path.

Behaviour:
- Reset:
  - Clock and reset are as decided: one clock, clk; reset rst, asynchronous, active-high.
  - While rst=1: state=IDLE, busy=0, done=0, length=0, perm_ok=0, edge index=0, accumulator=0, seen mask=0.
  - Reset mid-run aborts the run; no done pulse is produced.
- States: IDLE, RUN.
- IDLE:
  - On the rising edge where start=1, path is copied into an internal snapshot (N x IDX_W flops).
  - Same edge: idx<=0, acc<=0, seen<=0, dup<=0, state<=RUN, busy<=1.
  - length and perm_ok keep their previous values until the next done.
- RUN, every edge:
  - a=snap[idx], b=snap[idx==N-1 ? 0 : idx+1].
  - d = |xs[a]-xs[b]| + |ys[a]-ys[b]|.
  - Each abs difference is computed at COORD_W+1 bits; d is COORD_W+2 bits, zero-extended into acc.
  - acc<=acc+d; seen[a]<=1; dup<=dup | seen[a]; idx<=idx+1.
- End of run (edge where idx==N-1):
  - length<=acc+d.
  - perm_ok<=~(dup | seen[a]). Since exactly N marks were made, no duplicates implies all indices are covered.
  - done<=1, busy<=0, state<=IDLE.
- Latency:
  - Start sampled at edge E0; done high after edge EN, i.e. exactly N cycles after start.
  - busy is high for exactly N cycles.
- done rules:
  - done is high for exactly one cycle and is cleared on the next edge unless another run ends there.
  - A start in the cycle done is high is accepted; the next run begins with no idle gap.
  - start while busy=1 is ignored: no restart and no snapshot update.
- Input stability:
  - path may change freely during RUN, because only the snapshot is used.
  - xs/ys are read live and must be held stable by the caller while busy. The solver's coordinates are fixed after generation.
- Index range: a path index >= N is not checked by the block. With N=2^IDX_W this cannot occur.
- Degenerate case: N=1 gives a=b every cycle, length=0, perm_ok=1 if snap[0]==0.
- Overflow: acc wraps modulo 2^LEN_W. No saturation; LEN_W sizing is the integrator's responsibility.

Test Plan:
- Identity line: xs[i]=i, ys[i]=0, path[i]=i, pulse start. Required: busy high 64 cycles, done pulse once, length=126 (63 unit edges + wrap edge 63), perm_ok=1.
- Max distance: xs[i]=ys[i]=(i odd ? 255 : 0), path[i]=i. Required: length=64*510=32640, perm_ok=1.
- Non-permutation: path all zeros, any coordinates. Required: length=0, perm_ok=0. Separately, identity path with path[5]=4: perm_ok=0 and length reflects the repeated city.
- Start while busy, plus snapshot isolation: run the identity case, pulse start again at cycle 10, and rewrite path to all zeros at cycle 20. Required: exactly one done at cycle 64, length=126, perm_ok=1.
- Reset mid-run: assert rst at cycle 30 of a run. Required: outputs 0 asynchronously, and no done. A fresh start after reset gives the full correct result.
- Back-to-back: assert start in the same cycle done is high. Required: second busy begins immediately, second done exactly 64 cycles later, and results match the path present at the second start.
